// File: rtl/regfile_write_port_if.sv
// Write-request handshake between a write-back source and the register-file write port.
interface regfile_write_port_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/regfile_write_port.sv
// Register-file write port: buffers write-back requests in a small FIFO and commits
// one entry per cycle into the architectural registers. r0 reads as constant zero.
module regfile_write_port #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                                  clock,
    input  logic                                  reset,
    regfile_write_port_if.slave                   wr,
    input  logic                                  hold,
    output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] regs_flat,
    output logic [(2**ADDR_WIDTH)-1:0]            commit_en,
    output logic [$clog2(DEPTH+1)-1:0]            pending,
    output logic                                  busy
);
    localparam int unsigned NUM_REGS = 2**ADDR_WIDTH;
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Write buffer storage and bookkeeping
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // Architectural registers r1..rN-1; r0 has no storage
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS-1:1];

    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    // Ready comes from registered occupancy only, so full never passes a request through
    assign wr.wr_ready = (count_q < DEPTH_C);
    assign push        = wr.wr_valid && wr.wr_ready;
    assign pop         = (count_q != '0) && !hold;
    assign head_addr   = addr_q[rptr_q];
    assign head_data   = data_q[rptr_q];
    assign pending     = count_q;
    assign busy        = (count_q != '0);

    // Decode the head destination into a one-hot enable; r0 is never enabled
    always_comb begin
        commit_en = '0;
        if (pop) begin
            commit_en[head_addr] = 1'b1;
        end
        commit_en[0] = 1'b0;
    end

    // Next-state for pointers and occupancy; simultaneous push and pop keeps the count
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Buffer pointers and occupancy; reset discards anything still buffered
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Buffer payload; contents are only meaningful while counted, so no reset is needed
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            addr_q[wptr_q] <= wr.wr_addr;
            data_q[wptr_q] <= wr.wr_data;
        end
    end

    // Architectural registers load the head entry when enabled
    always_ff @(posedge clock) begin
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (reset) begin
                regs_q[i] <= '0;
            end else if (commit_en[i]) begin
                regs_q[i] <= head_data;
            end
        end
    end

    // Flatten the register file for the read-select muxes; r0 slice stays zero
    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    end
endmodule
